fetch_target_queue: RTL

- IFU-side counterpart of the BPU request/response handshake.
- Owns the architectural fetch PC and presents it to the BPU every cycle. On each accepted prediction it records {pc, pred_slot_valid, pred_slot_idx, pred_slot_target} in a FIFO and advances the PC to the predicted npc.
- Buffered fetch targets are drained in order by the ICache/fetch stage.
- A backend flush clears the queue and restarts prediction from a redirect PC.

---
 rtl/fetch_target_queue_if.sv | 61 ++++++
 rtl/fetch_target_queue.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_target_queue_if.sv
// Configuration package and the BPU/fetch/flush bundle between the fetch target
// queue and its neighbours.
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned INSTR_PER_FETCH;
  } cfg_t;

  localparam cfg_t Cfg = '{XLEN: 32, INSTR_PER_FETCH: 4};
endpackage

interface fetch_target_queue_if #(
  parameter config_pkg::cfg_t Cfg   = config_pkg::Cfg,
  parameter int unsigned      DEPTH = 8
);
  localparam int unsigned XLEN = Cfg.XLEN;
  localparam int unsigned IDXW = (Cfg.INSTR_PER_FETCH > 1) ? $clog2(Cfg.INSTR_PER_FETCH) : 1;
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  logic            bpu_req_valid_o;
  logic            bpu_req_ready_o;
  logic [XLEN-1:0] bpu_pc_o;
  logic            bpu_resp_valid_i;
  logic [XLEN-1:0] bpu_npc_i;
  logic            bpu_pred_slot_valid_i;
  logic [IDXW-1:0] bpu_pred_slot_idx_i;
  logic [XLEN-1:0] bpu_pred_slot_target_i;

  logic            fetch_valid_o;
  logic            fetch_ready_i;
  logic [XLEN-1:0] fetch_pc_o;
  logic            fetch_pred_slot_valid_o;
  logic [IDXW-1:0] fetch_pred_slot_idx_o;
  logic [XLEN-1:0] fetch_pred_slot_target_o;
  logic [PTRW-1:0] fetch_ftq_idx_o;

  logic            flush_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [CNTW-1:0] count_o;

  modport master (
    output bpu_req_valid_o, bpu_req_ready_o, bpu_pc_o,
    input  bpu_resp_valid_i, bpu_npc_i, bpu_pred_slot_valid_i,
           bpu_pred_slot_idx_i, bpu_pred_slot_target_i,
    output fetch_valid_o, fetch_pc_o, fetch_pred_slot_valid_o,
           fetch_pred_slot_idx_o, fetch_pred_slot_target_o, fetch_ftq_idx_o,
    input  fetch_ready_i, flush_i, redirect_pc_i,
    output count_o
  );

  modport slave (
    input  bpu_req_valid_o, bpu_req_ready_o, bpu_pc_o,
    output bpu_resp_valid_i, bpu_npc_i, bpu_pred_slot_valid_i,
           bpu_pred_slot_idx_i, bpu_pred_slot_target_i,
    input  fetch_valid_o, fetch_pc_o, fetch_pred_slot_valid_o,
           fetch_pred_slot_idx_o, fetch_pred_slot_target_o, fetch_ftq_idx_o,
    output fetch_ready_i, flush_i, redirect_pc_i,
    input  count_o
  );
endinterface

// File: rtl/fetch_target_queue.sv
// Fetch target queue: owns the fetch PC, records accepted BPU predictions in a
// FIFO and hands them to the fetch stage in order; a flush restarts from a redirect PC.
module fetch_target_queue #(
  parameter config_pkg::cfg_t Cfg      = config_pkg::Cfg,
  parameter int unsigned      DEPTH    = 8,
  parameter logic [31:0]      RESET_PC = 32'h8000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  fetch_target_queue_if.master    bus
);
  localparam int unsigned XLEN = Cfg.XLEN;
  localparam int unsigned IDXW = (Cfg.INSTR_PER_FETCH > 1) ? $clog2(Cfg.INSTR_PER_FETCH) : 1;
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            slot_valid;
    logic [IDXW-1:0] slot_idx;
    logic [XLEN-1:0] slot_target;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            req_valid_q, req_valid_d;

  logic   req_ready;
  logic   head_valid;
  logic   enq;
  logic   deq;
  entry_t head_entry;

  assign req_ready  = (count_q != CNTW'(DEPTH));
  assign head_valid = (count_q != '0);
  assign enq        = req_valid_q & req_ready & bus.bpu_resp_valid_i & ~bus.flush_i;
  assign deq        = head_valid & bus.fetch_ready_i & ~bus.flush_i;
  assign head_entry = mem_q[head_q];

  always_comb begin
    mem_d       = mem_q;
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    // A flush opens a one-cycle bubble before requests resume from the redirect PC.
    req_valid_d = ~bus.flush_i;

    if (bus.flush_i) begin
      pc_d    = bus.redirect_pc_i;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[tail_q] = '{pc:          pc_q,
                          slot_valid:  bus.bpu_pred_slot_valid_i,
                          slot_idx:    bus.bpu_pred_slot_idx_i,
                          slot_target: bus.bpu_pred_slot_target_i};
        tail_d = tail_q + PTRW'(1);
        pc_d   = bus.bpu_npc_i;
      end
      if (deq) begin
        head_d = head_q + PTRW'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q       <= '{default: '0};
      pc_q        <= XLEN'(RESET_PC);
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      req_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign bus.bpu_req_valid_o = req_valid_q;
  assign bus.bpu_req_ready_o = req_ready;
  assign bus.bpu_pc_o        = pc_q;

  // Payload is masked when empty so stale slots never leak out after flush or reset.
  assign bus.fetch_valid_o            = head_valid;
  assign bus.fetch_pc_o               = head_valid ? head_entry.pc : '0;
  assign bus.fetch_pred_slot_valid_o  = head_valid & head_entry.slot_valid;
  assign bus.fetch_pred_slot_idx_o    = head_valid ? head_entry.slot_idx : '0;
  assign bus.fetch_pred_slot_target_o = head_valid ? head_entry.slot_target : '0;
  assign bus.fetch_ftq_idx_o          = head_q;
  assign bus.count_o                  = count_q;
endmodule
